// File: rtl/uwasic_onboarding_joel_crasto_pkg.sv
// Shared constants and the SPI frame layout for the onboarding tile.
package uwasic_onboarding_joel_crasto_pkg;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;
   localparam logic [6:0] MAX_ADDR       = 7'd4;
   localparam int         NUM_REGS       = 5;
   localparam int         FRAME_BITS     = 16;
   localparam logic [3:0] PRESCALE_MAX   = 4'd12;

   typedef struct packed {
      logic       write;
      logic [6:0] addr;
      logic [7:0] data;
   } spi_frame_t;

endpackage

// File: rtl/uwasic_onboarding_joel_crasto_pwm_peripheral.sv
// Free-running ~3 kHz PWM shared by 16 channels, each forced low, forced high or PWM.
module pwm_peripheral
   import uwasic_onboarding_joel_crasto_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] en_out_i,
   input  logic [15:0] en_pwm_i,
   input  logic [7:0]  duty_i,
   output logic [15:0] chan_o
);

   logic [3:0] prescale_q;
   logic [3:0] prescale_d;
   logic [7:0] pwm_cnt_q;
   logic [7:0] pwm_cnt_d;
   logic       tick;
   logic       pwm;

   assign tick       = (prescale_q == PRESCALE_MAX);
   assign prescale_d = tick ? 4'd0 : prescale_q + 4'd1;
   assign pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q <= 4'd0;
         pwm_cnt_q  <= 8'd0;
      end else begin
         prescale_q <= prescale_d;
         pwm_cnt_q  <= pwm_cnt_d;
      end
   end

   // Full scale is special-cased so duty FF is a solid high rather than 255/256.
   assign pwm = (duty_i == 8'hFF) | (pwm_cnt_q < duty_i);

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_chan
         assign chan_o[gi] = en_out_i[gi] & (~en_pwm_i[gi] | pwm);
      end
   endgenerate

endmodule

// File: rtl/uwasic_onboarding_joel_crasto.sv
// Tile top: write-only SPI (mode 0) register file driving 16 PWM-capable output pins.
module uwasic_onboarding_joel_crasto
   import uwasic_onboarding_joel_crasto_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [1:0]  sclk_sync_q;
   logic [1:0]  copi_sync_q;
   logic [1:0]  ncs_sync_q;
   logic        sclk_prev_q;
   logic        ncs_prev_q;
   logic [4:0]  bit_cnt_q;
   logic [4:0]  bit_cnt_d;
   logic [15:0] shift_q;
   logic [15:0] shift_d;
   logic [7:0]  regs_q [NUM_REGS];
   logic        sclk_s;
   logic        copi_s;
   logic        ncs_s;
   logic        sclk_rise;
   logic        ncs_fall;
   logic        ncs_rise;
   logic        commit;
   spi_frame_t  frame;
   logic [15:0] chan;
   logic        unused_inputs;

   assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in};

   assign sclk_s    = sclk_sync_q[1];
   assign copi_s    = copi_sync_q[1];
   assign ncs_s     = ncs_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ncs_fall  = ~ncs_s & ncs_prev_q;
   assign ncs_rise  = ncs_s & ~ncs_prev_q;

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (ncs_fall) begin
         bit_cnt_d = 5'd0;
         shift_d   = 16'd0;
      end else if (!ncs_s && sclk_rise) begin
         shift_d = {shift_q[14:0], copi_s};
         if (bit_cnt_q != 5'd31) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
         end
      end
   end

   // Only exact 16-bit write frames to a mapped address reach the register file.
   assign frame  = spi_frame_t'(shift_q);
   assign commit = ncs_rise && (bit_cnt_q == 5'(FRAME_BITS)) && frame.write
                   && (frame.addr <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= 2'b00;
         copi_sync_q <= 2'b00;
         ncs_sync_q  <= 2'b00;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b0;
         bit_cnt_q   <= 5'd0;
         shift_q     <= 16'd0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], ui_in[0]};
         copi_sync_q <= {copi_sync_q[0], ui_in[1]};
         ncs_sync_q  <= {ncs_sync_q[0], ui_in[2]};
         sclk_prev_q <= sclk_s;
         ncs_prev_q  <= ncs_s;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (frame.addr == 7'(i))) begin
               regs_q[i] <= frame.data;
            end
         end
      end
   end

   pwm_peripheral u_pwm (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_out_i ({regs_q[ADDR_EN_OUT_HI[2:0]], regs_q[ADDR_EN_OUT_LO[2:0]]}),
      .en_pwm_i ({regs_q[ADDR_EN_PWM_HI[2:0]], regs_q[ADDR_EN_PWM_LO[2:0]]}),
      .duty_i   (regs_q[ADDR_DUTY[2:0]]),
      .chan_o   (chan)
   );

   assign uo_out  = chan[7:0];
   assign uio_out = chan[15:8];
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_joel_crasto.sv
// Self-checking bench: directed vector table, random frames against a register/PWM model, PWM timing.
module tb_uwasic_onboarding_joel_crasto;

   typedef struct {
      string       name;
      logic [31:0] word;
      int          nbits;
      logic [7:0]  exp_uo;
      logic [7:0]  exp_uio;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int         n_cmp;
   int         n_bad;
   int         n_cyc;
   logic [7:0] m_regs [5];
   vec_t       vecs [7];

   uwasic_onboarding_joel_crasto dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Elapsed clk cycles since reset release; the PWM phase is derived from this.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_cyc <= 0;
      else        n_cyc <= n_cyc + 1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int lo, input int hi);
      n_cmp++;
      if (got < lo || got > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic spi_send(input logic [31:0] word, input int nbits, input int half);
      ui_in[2] = 1'b0;
      wait_cyc(half);
      for (int b = nbits - 1; b >= 0; b--) begin
         ui_in[0] = 1'b0;
         ui_in[1] = word[b];
         wait_cyc(half);
         ui_in[0] = 1'b1;
         wait_cyc(half);
      end
      ui_in[0] = 1'b0;
      wait_cyc(half);
      ui_in[2] = 1'b1;
      wait_cyc(8);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
   endfunction

   function automatic void model_frame(input logic [31:0] word, input int nbits);
      int addr;
      if (nbits != 16) return;
      addr = int'(word[14:8]);
      if (word[15] && addr <= 4) m_regs[addr] = word[7:0];
   endfunction

   function automatic logic [15:0] model_pins(input int cyc);
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic        pwm;
      logic [15:0] pins;
      int          phase;
      en_out = {m_regs[1], m_regs[0]};
      en_pwm = {m_regs[3], m_regs[2]};
      phase  = (cyc / 13) % 256;
      pwm    = (m_regs[4] == 8'hFF) || (phase < int'(m_regs[4]));
      for (int i = 0; i < 16; i++) begin
         pins[i] = en_out[i] ? (en_pwm[i] ? pwm : 1'b1) : 1'b0;
      end
      return pins;
   endfunction

   initial begin
      logic [31:0] word;
      logic [15:0] exp_pins;
      int          nbits;
      int          cnt;
      int          high_t;
      int          low_t;
      logic        ok;
      logic        prev;

      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h04;
      uio_in = 8'h00;
      model_reset();

      vecs[0] = '{"wr_en_out_lo", 32'h80F0, 16, 8'hF0, 8'h00};
      vecs[1] = '{"wr_en_out_hi", 32'h81CC, 16, 8'hF0, 8'hCC};
      vecs[2] = '{"read_frame",   32'h0055, 16, 8'hF0, 8'hCC};
      vecs[3] = '{"bad_addr",     32'h8555, 16, 8'hF0, 8'hCC};
      vecs[4] = '{"short_15",     32'h7F11, 15, 8'hF0, 8'hCC};
      vecs[5] = '{"long_17",      32'h08011, 17, 8'hF0, 8'hCC};
      vecs[6] = '{"wr_hi_again",  32'h8133, 16, 8'hF0, 8'h33};

      wait_cyc(5);
      check8("reset_uo", uo_out, 8'h00);
      check8("reset_uio", uio_out, 8'h00);
      rst_n = 1'b1;
      wait_cyc(3);
      check8("reset_oe", uio_oe, 8'hFF);
      check8("post_reset_uo", uo_out, 8'h00);

      for (int v = 0; v < 7; v++) begin
         spi_send(vecs[v].word, vecs[v].nbits, 5);
         $display("vec %s word=%05h bits=%0d uo=%02h uio=%02h", vecs[v].name,
                  vecs[v].word, vecs[v].nbits, uo_out, uio_out);
         check8({vecs[v].name, "_uo"}, uo_out, vecs[v].exp_uo);
         check8({vecs[v].name, "_uio"}, uio_out, vecs[v].exp_uio);
         model_frame(vecs[v].word, vecs[v].nbits);
      end

      for (int t = 0; t < 30; t++) begin
         word  = {16'h0, $urandom_range(0, 1) == 1, 7'($urandom_range(0, 7)), 8'($urandom)};
         cnt   = $urandom_range(0, 4);
         nbits = (cnt == 0) ? 15 : (cnt == 1) ? 17 : 16;
         if (nbits == 17) word[16] = 1'($urandom);
         spi_send(word, nbits, $urandom_range(4, 7));
         model_frame(word, nbits);
         exp_pins = model_pins(n_cyc);
         $display("rnd %0d word=%05h bits=%0d uo=%02h uio=%02h", t, word, nbits, uo_out, uio_out);
         check8("rnd_uo", uo_out, exp_pins[7:0]);
         check8("rnd_uio", uio_out, exp_pins[15:8]);
      end

      spi_send(32'h8001, 16, 5);
      spi_send(32'h8201, 16, 5);
      spi_send(32'h8480, 16, 5);
      prev = uo_out[0];
      ok   = 1'b0;
      for (int c = 0; c < 4000 && !ok; c++) begin
         @(negedge clk);
         if (!prev && uo_out[0]) ok = 1'b1;
         prev = uo_out[0];
      end
      high_t = 0;
      low_t  = 0;
      if (ok) begin
         while (uo_out[0] && high_t < 4000) begin
            @(negedge clk);
            high_t++;
         end
         while (!uo_out[0] && low_t < 4000) begin
            @(negedge clk);
            low_t++;
         end
      end
      $display("pwm50 high=%0d period=%0d", high_t, high_t + low_t);
      check_int("pwm50_high", high_t, 1662, 1666);
      check_int("pwm50_period", high_t + low_t, 3326, 3330);

      spi_send(32'h8400, 16, 5);
      cnt = 0;
      for (int c = 0; c < 6656; c++) begin
         @(negedge clk);
         if (uo_out[0] !== 1'b0) cnt++;
      end
      $display("duty00 high_samples=%0d", cnt);
      check_int("duty00_const", cnt, 0, 0);

      spi_send(32'h84FF, 16, 5);
      cnt = 0;
      for (int c = 0; c < 6656; c++) begin
         @(negedge clk);
         if (uo_out[0] !== 1'b1) cnt++;
      end
      $display("dutyFF low_samples=%0d", cnt);
      check_int("dutyFF_const", cnt, 0, 0);

      ui_in[2] = 1'b0;
      wait_cyc(5);
      for (int b = 15; b >= 8; b--) begin
         ui_in[0] = 1'b0;
         ui_in[1] = ((32'h81FF >> b) & 1) != 0;
         wait_cyc(5);
         ui_in[0] = 1'b1;
         wait_cyc(5);
      end
      rst_n = 1'b0;
      model_reset();
      wait_cyc(5);
      rst_n    = 1'b1;
      ui_in[0] = 1'b0;
      ui_in[2] = 1'b1;
      wait_cyc(8);
      spi_send(32'h80AA, 16, 5);
      $display("midreset uo=%02h uio=%02h", uo_out, uio_out);
      check8("midreset_uo", uo_out, 8'hAA);
      check8("midreset_uio", uio_out, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
